// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, exec-unit FSM states and shift-amount width.
// Imported by the ALU controller and by alu_exec_unit / alu_shifter.
package alu_pkg;

  localparam int SHAMT_W = 5;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_XOR  = 4'b0010,
    OP_OR   = 4'b0011,
    OP_AND  = 4'b0100,
    OP_SRL  = 4'b0101,
    OP_SLL  = 4'b0110,
    OP_SRA  = 4'b0111,
    OP_SLT  = 4'b1000,
    OP_SLTU = 4'b1001,
    OP_EQ   = 4'b1010
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_t;

endpackage

// File: rtl/alu_shifter.sv
// Shift datapath for alu_exec_unit. Default build shifts one bit per use (iterative);
// with ALU_BARREL_SHIFT_EN defined it shifts by the full amount combinationally.
module alu_shifter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  alu_op_t               i_op,
  input  logic [DATA_WIDTH-1:0] i_data,
`ifdef ALU_BARREL_SHIFT_EN
  input  logic [SHAMT_W-1:0]    i_shamt,
`endif
  output logic [DATA_WIDTH-1:0] o_data
);

  logic [SHAMT_W-1:0] w_amt;

`ifdef ALU_BARREL_SHIFT_EN
  assign w_amt = i_shamt;
`else
  assign w_amt = SHAMT_W'(1);
`endif

  always_comb begin
    o_data = i_data;
    case (i_op)
      OP_SRL:  o_data = i_data >> w_amt;
      OP_SLL:  o_data = i_data << w_amt;
      OP_SRA:  o_data = DATA_WIDTH'($signed(i_data) >>> w_amt);
      default: o_data = i_data;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit with valid/ready handshake and IDLE/BUSY/DONE control.
// Macro ALU_BARREL_SHIFT_EN selects single-cycle shifts; otherwise shifts iterate one bit per cycle.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            Operation,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] ALUResult,
  output logic                  Zero,
  output logic                  Illegal
);

  alu_state_t            r_state;
  logic                  r_in_ready;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_result;
  logic                  r_zero;
  logic                  r_illegal;

  alu_op_t               w_op;
  logic [SHAMT_W-1:0]    w_shamt;
  logic [DATA_WIDTH-1:0] w_shift;
  logic [DATA_WIDTH-1:0] w_result;
  logic                  w_illegal;

  assign w_op    = alu_op_t'(Operation);
  assign w_shamt = SrcB[SHAMT_W-1:0];

`ifdef ALU_BARREL_SHIFT_EN
  alu_shifter #(.DATA_WIDTH(DATA_WIDTH)) u_shifter (
    .i_op    (w_op),
    .i_data  (SrcA),
    .i_shamt (w_shamt),
    .o_data  (w_shift)
  );
`else
  alu_op_t            r_op;
  logic [SHAMT_W-1:0] r_cnt;
  logic               w_is_shift;

  assign w_is_shift = (w_op == OP_SRL) || (w_op == OP_SLL) || (w_op == OP_SRA);

  // Iterative mode: the shifter steps the in-flight result register by one bit.
  alu_shifter #(.DATA_WIDTH(DATA_WIDTH)) u_shifter (
    .i_op   (r_op),
    .i_data (r_result),
    .o_data (w_shift)
  );
`endif

  always_comb begin
    w_result  = '0;
    w_illegal = 1'b0;
    case (w_op)
      OP_ADD:  w_result = SrcA + SrcB;
      OP_SUB:  w_result = SrcA - SrcB;
      OP_XOR:  w_result = SrcA ^ SrcB;
      OP_OR:   w_result = SrcA | SrcB;
      OP_AND:  w_result = SrcA & SrcB;
      OP_SLT:  w_result = DATA_WIDTH'($signed(SrcA) < $signed(SrcB));
      OP_SLTU: w_result = DATA_WIDTH'(SrcA < SrcB);
      OP_EQ:   w_result = DATA_WIDTH'(SrcA == SrcB);
`ifdef ALU_BARREL_SHIFT_EN
      OP_SRL, OP_SLL, OP_SRA: w_result = w_shift;
`else
      // Only reached here for a zero shift amount; nonzero amounts go through BUSY.
      OP_SRL, OP_SLL, OP_SRA: w_result = SrcA;
`endif
      default: w_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_illegal   <= 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
      r_op        <= OP_ADD;
      r_cnt       <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_in_ready <= 1'b0;
            r_illegal  <= w_illegal;
`ifndef ALU_BARREL_SHIFT_EN
            r_op       <= w_op;
            if (w_is_shift && (w_shamt != '0)) begin
              r_result <= SrcA;
              r_cnt    <= w_shamt;
              r_state  <= ST_BUSY;
            end else begin
`else
            begin
`endif
              r_result    <= w_result;
              r_zero      <= (w_result == '0);
              r_out_valid <= 1'b1;
              r_state     <= ST_DONE;
            end
          end
        end
`ifndef ALU_BARREL_SHIFT_EN
        ST_BUSY: begin
          r_result <= w_shift;
          r_cnt    <= r_cnt - SHAMT_W'(1);
          if (r_cnt == SHAMT_W'(1)) begin
            r_zero      <= (w_shift == '0);
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
`endif
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign ALUResult = r_result;
  assign Zero      = r_zero;
  assign Illegal   = r_illegal;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit; honours ALU_BARREL_SHIFT_EN for expected latencies.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  Operation;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALUResult;
  logic        Zero;
  logic        Illegal;

  alu_exec_unit #(.DATA_WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Operation (Operation),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALUResult (ALUResult),
    .Zero      (Zero),
    .Illegal   (Illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic        ill;
    int unsigned lat;
    int unsigned acc;
  } sb_t;

  sb_t         sb[$];
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  logic        prev_v = 1'b0;
  logic [31:0] held;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, output logic ill);
    ill = 1'b0;
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a ^ b;
      4'd3:    return a | b;
      4'd4:    return a & b;
      4'd5:    return a >> b[4:0];
      4'd6:    return a << b[4:0];
      4'd7:    return 32'($signed(a) >>> b[4:0]);
      4'd8:    return {31'd0, $signed(a) < $signed(b)};
      4'd9:    return {31'd0, a < b};
      4'd10:   return {31'd0, a == b};
      default: begin ill = 1'b1; return 32'd0; end
    endcase
  endfunction

  function automatic int unsigned exp_lat(input logic [3:0] op, input logic [31:0] b);
`ifdef ALU_BARREL_SHIFT_EN
    return 1;
`else
    if (op >= 4'd5 && op <= 4'd7 && b[4:0] != 5'd0) return 32'(b[4:0]) + 1;
    return 1;
`endif
  endfunction

  // Result monitor: compare on the rising edge of out_valid, then require stability while held.
  always @(negedge clk) begin
    sb_t e;
    if (reset) begin
      prev_v = 1'b0;
    end else begin
      if (out_valid && !prev_v) begin
        if (sb.size() == 0) begin
          chk("spurious_out", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          chk("result",  ALUResult, e.res);
          chk("zero",    32'(Zero), 32'(e.zero));
          chk("illegal", 32'(Illegal), 32'(e.ill));
          chk("latency", cyc - e.acc + 1, e.lat);
          held = e.res;
        end
      end else if (out_valid && prev_v) begin
        chk("hold_result", ALUResult, held);
      end
      prev_v = out_valid;
    end
  end

  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    sb_t         e;
    logic        ill;
    int unsigned t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    Operation = op;
    SrcA      = a;
    SrcB      = b;
    e.res  = model(op, a, b, ill);
    e.ill  = ill;
    e.zero = (e.res == 32'd0);
    e.lat  = exp_lat(op, b);
    e.acc  = 0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    sb[sb.size()-1].acc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t;
    logic [3:0]  op;
    logic [31:0] b;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    Operation = '0; SrcA = '0; SrcB = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready",  32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result",    ALUResult, 32'd0);
    chk("rst_zero",      32'(Zero), 32'd0);
    chk("rst_illegal",   32'(Illegal), 32'd0);

    send(4'd0, 32'h7FFF_FFFF, 32'h0000_0001); drain();
    send(4'd1, 32'd5, 32'd5);                 drain();
    send(4'd10, 32'd7, 32'd7);                drain();
    send(4'd10, 32'd7, 32'd8);                drain();
    send(4'd8, 32'hFFFF_FFFF, 32'd1);         drain();
    send(4'd9, 32'hFFFF_FFFF, 32'd1);         drain();
    send(4'd2, 32'hF0F0_1234, 32'h0FF0_4321); drain();
    send(4'd3, 32'hA000_0005, 32'h0500_0050); drain();
    send(4'd4, 32'hFFFF_0000, 32'h1234_5678); drain();
    send(4'd5, 32'h8000_0000, 32'd4);         drain();
    send(4'd6, 32'h0000_0003, 32'd30);        drain();
    send(4'd6, 32'h1234_5678, 32'd0);         drain();
    send(4'd7, 32'h8000_0000, 32'd31);        drain();
    send(4'd7, 32'h4000_0000, 32'h0000_0021); drain();
    send(4'hF, 32'd1, 32'd2);                 drain();
    send(4'hB, 32'd3, 32'd3);                 drain();

    // Backpressure: hold result in DONE while a new request is offered and ignored.
    out_ready = 1'b0;
    send(4'd0, 32'd3, 32'd4);
    t = 0;
    while (!out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("bp_valid_wait", 32'(out_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      in_valid = 1'b1; Operation = 4'd1; SrcA = 32'd100; SrcB = 32'd1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_out_valid_low", 32'(out_valid), 32'd0);
    chk("bp_idle_ready",    32'(in_ready), 32'd1);
    repeat (3) @(negedge clk);

    // Reset while an SLL by 20 is in flight.
    send(4'd6, 32'h0000_0001, 32'd20);
    repeat (5) @(negedge clk);
`ifndef ALU_BARREL_SHIFT_EN
    chk("busy_in_ready", 32'(in_ready), 32'd0);
`endif
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready",  32'(in_ready), 32'd1);
    repeat (30) @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      op = 4'($urandom_range(0, 10));
      b  = $urandom;
      send(op, $urandom, b);
      drain();
    end

    chk("sb_final_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
